// File: rtl/input_conditioner_if.sv
// Bus between the board-pin side and the input conditioner: raw pins and game requests in,
// debounced channel state, edge pulses, sticky presses and the LED pin out.
interface input_conditioner_if #(
    parameter int N_CH = 3
);
    logic [N_CH-1:0] raw_in;
    logic            clear_inputs;
    logic            led_req;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] pressed;
    logic            LED_OUT;

    modport master (
        output raw_in, clear_inputs, led_req,
        input  level, rise, fall, pressed, LED_OUT
    );

    modport slave (
        input  raw_in, clear_inputs, led_req,
        output level, rise, fall, pressed, LED_OUT
    );
endinterface

// File: rtl/input_conditioner.sv
// N-channel control front end: synchroniser, polarity fix, debouncer, edge pulses, sticky presses, LED pin.
// Optional macro INPUT_REPEAT_EN adds auto-repeat rise pulses while a channel stays asserted.
module input_conditioner #(
    parameter int              N_CH            = 3,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 16,
    parameter logic [N_CH-1:0] ACTIVE_LOW      = {N_CH{1'b1}},
    parameter logic            LED_ACTIVE_LOW  = 1'b0,
    parameter int              REPEAT_CYCLES   = 32
) (
    input logic                  clock,
    input logic                  reset,
    input_conditioner_if.slave   io
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("input_conditioner: illegal parameter value");
    end

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]   cnt_q  [N_CH];
    logic [CW-1:0]   cnt_d  [N_CH];
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;
    logic [N_CH-1:0] pressed_q, pressed_d;
    logic            led_q, led_d;
    logic [N_CH-1:0] samp_s;
    logic [N_CH-1:0] accept_s;

`ifdef INPUT_REPEAT_EN
    localparam int            HW        = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_CYCLES - 1);
    logic [HW-1:0] hold_q [N_CH];
    logic [HW-1:0] hold_d [N_CH];
`endif

    // Next-state logic: synchroniser shift, debounce counters, edge pulses, sticky flags, LED.
    always_comb begin
        sync_d[0] = io.raw_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        samp_s   = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
        accept_s = {N_CH{1'b0}};
        level_d  = level_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (samp_s[i] == level_q[i]) begin
                cnt_d[i] = {CW{1'b0}};
            end else if (cnt_q[i] == CNT_LAST) begin
                accept_s[i] = 1'b1;
                level_d[i]  = samp_s[i];
                cnt_d[i]    = {CW{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        rise_d = accept_s & samp_s;
        fall_d = accept_s & ~samp_s;
`ifdef INPUT_REPEAT_EN
        // Hold counter restarts at every accept and idles at zero while the channel is released.
        for (int i = 0; i < N_CH; i++) begin
            hold_d[i] = hold_q[i];
            if (accept_s[i] || !level_q[i]) begin
                hold_d[i] = {HW{1'b0}};
            end else if (hold_q[i] == HOLD_LAST) begin
                hold_d[i] = {HW{1'b0}};
                rise_d[i] = 1'b1;
            end else begin
                hold_d[i] = hold_q[i] + HW'(1);
            end
        end
`endif
        // A new rise always survives a coincident clear so no press is ever lost.
        if (io.clear_inputs) begin
            pressed_d = rise_d;
        end else begin
            pressed_d = pressed_q | rise_d;
        end
        led_d = io.led_req ^ LED_ACTIVE_LOW;
    end

    // State registers; sync flops reset to the idle pin level so reset never looks like a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= ACTIVE_LOW;
            end
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
            level_q   <= {N_CH{1'b0}};
            rise_q    <= {N_CH{1'b0}};
            fall_q    <= {N_CH{1'b0}};
            pressed_q <= {N_CH{1'b0}};
            led_q     <= LED_ACTIVE_LOW;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pressed_q <= pressed_d;
            led_q     <= led_d;
        end
    end

`ifdef INPUT_REPEAT_EN
    // Auto-repeat hold counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                hold_q[i] <= {HW{1'b0}};
            end
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign io.level   = level_q;
    assign io.rise    = rise_q;
    assign io.fall    = fall_q;
    assign io.pressed = pressed_q;
    assign io.LED_OUT = led_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a window-based behavioural model.
module tb_input_conditioner;
    localparam int       N  = 3;
    localparam int       SS = 2;
    localparam int       D  = 4;
    localparam int       R  = 8;
    localparam logic [2:0] AL = 3'b100;
    localparam logic       LA = 1'b0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    input_conditioner_if #(.N_CH(N)) bus();

    input_conditioner #(
        .N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW(AL), .LED_ACTIVE_LOW(LA), .REPEAT_CYCLES(R)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io(bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A change is accepted once the last D normalised samples (since the previous accept) all disagree with level.
    logic [2:0] m_dl [SS];
    bit         hq [N][$];
    logic [2:0] m_level, m_rise, m_fall, m_pressed;
    logic       m_led;
    int         m_since [N];
    logic [2:0] m_s, m_nr, m_nf;
    bit         m_all;

    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SS; k++) m_dl[k] = AL;
            for (int i = 0; i < N; i++) begin
                hq[i].delete();
                m_since[i] = 0;
            end
            m_level = 3'b000; m_rise = 3'b000; m_fall = 3'b000; m_pressed = 3'b000;
            m_led = LA;
        end else begin
            m_s = m_dl[SS-1] ^ AL;
            for (int k = SS-1; k > 0; k--) m_dl[k] = m_dl[k-1];
            m_dl[0] = bus.raw_in;
            m_nr = 3'b000;
            m_nf = 3'b000;
            for (int i = 0; i < N; i++) begin
                hq[i].push_back(m_s[i]);
                if (hq[i].size() > D) void'(hq[i].pop_front());
                m_all = (hq[i].size() == D);
                foreach (hq[i][j]) if (hq[i][j] == m_level[i]) m_all = 1'b0;
                if (m_all) begin
                    hq[i].delete();
                    m_level[i] = m_s[i];
                    m_nr[i] = m_s[i];
                    m_nf[i] = ~m_s[i];
                    m_since[i] = 0;
                end else if (m_level[i]) begin
                    m_since[i]++;
`ifdef INPUT_REPEAT_EN
                    if (m_since[i] == R) begin
                        m_nr[i] = 1'b1;
                        m_since[i] = 0;
                    end
`endif
                end else begin
                    m_since[i] = 0;
                end
            end
            m_pressed = (bus.clear_inputs ? 3'b000 : m_pressed) | m_nr;
            m_rise = m_nr;
            m_fall = m_nf;
            m_led  = bus.led_req ^ LA;
        end
    end

    // Compare DUT against model on every out-of-reset cycle, half a period after the edge.
    always @(negedge clock) begin
        if (!reset) begin
            check("model_compare",
                  32'({bus.level, bus.rise, bus.fall, bus.pressed, bus.LED_OUT}),
                  32'({m_level, m_rise, m_fall, m_pressed, m_led}));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    int cnt;
    logic [31:0] mask;
    logic [8:0] chatter;

    initial begin
        bus.raw_in = AL;
        bus.clear_inputs = 1'b0;
        bus.led_req = 1'b0;
        chatter = 9'b111101101;   // bit k applied on step k: 1,0,1,1,0,1,1,1,1

        // 1. reset state, no spurious rise afterwards
        tick(3);
        check("reset_outputs", 32'({bus.level, bus.rise, bus.fall, bus.pressed, bus.LED_OUT}), 32'd0);
        reset = 1'b0;
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            tick(1);
            if (bus.rise != 3'b000) cnt++;
        end
        check("no_rise_after_reset", 32'(cnt), 32'd0);
        check("level_idle", 32'(bus.level), 32'd0);

        // LED latency and polarity
        bus.led_req = 1'b1;
        tick(1);
        check("led_on", 32'(bus.LED_OUT), 32'd1);
        bus.led_req = 1'b0;
        tick(1);
        check("led_off", 32'(bus.LED_OUT), 32'd0);

        // 2. clean step on channel 0: visible exactly 6 edges later
        bus.raw_in = 3'b101;
        tick(5);
        check("step_level_early", 32'(bus.level), 32'd0);
        tick(1);
        check("step_rise", 32'(bus.rise), 32'b001);
        check("step_level", 32'(bus.level), 32'b001);
        tick(1);
        check("step_rise_1cyc", 32'(bus.rise), 32'd0);
        check("step_pressed", 32'(bus.pressed), 32'b001);

        // 3. active-low channel 2: 3-cycle glitch rejected, 4-cycle pulse accepted
        bus.raw_in = 3'b001;
        tick(3);
        bus.raw_in = 3'b101;
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            tick(1);
            if (bus.rise[2] || bus.level[2]) cnt++;
        end
        check("glitch3_ignored", 32'(cnt), 32'd0);
        check("glitch3_pressed", 32'(bus.pressed[2]), 32'd0);
        bus.raw_in = 3'b001;
        tick(4);
        bus.raw_in = 3'b101;
        cnt = 0;
        for (int t = 0; t < 12; t++) begin
            tick(1);
            if (bus.rise[2]) cnt++;
        end
        check("pulse4_rise_once", 32'(cnt), 32'd1);
        check("pulse4_pressed", 32'(bus.pressed[2]), 32'd1);

        // release channel 0 so later literal checks are not disturbed
        bus.raw_in = 3'b100;
        tick(12);

        // 4. rise on channel 1 coincident with clear: set wins
        bus.raw_in = 3'b110;
        tick(5);
        bus.clear_inputs = 1'b1;
        tick(1);
        bus.clear_inputs = 1'b0;
        check("clear_vs_rise_rise", 32'(bus.rise), 32'b010);
        check("clear_vs_rise_pressed", 32'(bus.pressed), 32'b010);
        bus.clear_inputs = 1'b1;
        tick(1);
        bus.clear_inputs = 1'b0;
        check("clear_alone", 32'(bus.pressed), 32'd0);
        bus.raw_in = 3'b100;
        tick(12);

        // 5. chatter on channel 0: single rise 6 edges after the final 0
        cnt = 0;
        for (int k = 0; k < 9; k++) begin
            bus.raw_in[0] = chatter[k];
            tick(1);
            if (bus.rise[0]) cnt++;
        end
        tick(1);
        if (bus.rise[0]) cnt++;
        check("chatter_no_early_rise", 32'(cnt), 32'd0);
        tick(1);
        check("chatter_rise", 32'(bus.rise[0]), 32'd1);
        cnt = 0;
        for (int t = 0; t < 5; t++) begin
            tick(1);
            if (bus.rise[0]) cnt++;
        end
        check("chatter_single_rise", 32'(cnt), 32'd0);
        bus.raw_in[0] = 1'b0;
        tick(12);

`ifdef INPUT_REPEAT_EN
        // 6. auto-repeat at +8, +16, +24 while held, one fall on release
        bus.raw_in[0] = 1'b1;
        tick(6);
        check("repeat_first_rise", 32'(bus.rise[0]), 32'd1);
        mask = 32'd0;
        for (int t = 1; t <= 30; t++) begin
            tick(1);
            if (bus.rise[0]) mask[t] = 1'b1;
        end
        check("repeat_positions", mask, (32'd1 << 8) | (32'd1 << 16) | (32'd1 << 24));
        bus.raw_in[0] = 1'b0;
        cnt = 0;
        for (int t = 0; t < 12; t++) begin
            tick(1);
            if (bus.fall[0]) cnt++;
        end
        check("repeat_release_fall", 32'(cnt), 32'd1);
`else
        mask = 32'd0;
`endif

        // randomized phase, with one reset in the middle of activity
        for (int it = 0; it < 400; it++) begin
            bus.raw_in = 3'($urandom);
            bus.clear_inputs = ($urandom_range(7, 0) == 0);
            bus.led_req = 1'($urandom);
            if (it == 200) begin
                reset = 1'b1;
                tick(1);
                check("mid_reset_outputs",
                      32'({bus.level, bus.rise, bus.fall, bus.pressed, bus.LED_OUT}), 32'd0);
                tick(1);
                reset = 1'b0;
            end
            tick($urandom_range(7, 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
